// File: rtl/pool_stream_max_if.sv
// pool_stream_max_if: control, pixel-in and pooled-out handshakes of the max-pooler
interface pool_stream_max_if #(
    parameter int DATA_W = 14
);
    logic              start;
    logic              full_width;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              frame_done;

    modport master (
        output start, full_width, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, frame_done
    );

    modport slave (
        input  start, full_width, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, frame_done
    );
endinterface

// File: rtl/pool_stream_max.sv
// pool_stream_max: streaming POOL_K x POOL_K max-pooler with full-width or per-lane packed compare
module pool_stream_max #(
    parameter int DATA_W = 14,
    parameter int LANES  = 2,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int POOL_K = 2
) (
    input logic              clk,
    input logic              a_reset,
    pool_stream_max_if.slave bus
);
    localparam int LW = DATA_W / LANES;
    localparam int NJ = IMG_W / POOL_K;
    localparam int NR = IMG_H / POOL_K;
    localparam int KW = $clog2(POOL_K);
    localparam int JW = NJ > 1 ? $clog2(NJ) : 1;
    localparam int RW = NR > 1 ? $clog2(NR) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(POOL_K - 1);
    localparam logic [JW-1:0] J_LAST = JW'(NJ - 1);
    localparam logic [RW-1:0] R_LAST = RW'(NR - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            r_state, w_next;
    logic              r_mode;
    logic [KW-1:0]     r_kc;
    logic [KW-1:0]     r_wr;
    logic [JW-1:0]     r_j;
    logic [RW-1:0]     r_row;
    logic [DATA_W-1:0] r_pbuf [NJ];
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_frame_done;
    logic              w_acc;
    logic              w_out_hs;
    logic              w_first;
    logic              w_win_last;
    logic              w_frame_last;
    logic              w_start;
    logic [DATA_W-1:0] w_max;

    // Lanes are compared independently in packed mode so no carry/borrow crosses a lane boundary.
    function automatic logic [DATA_W-1:0] f_max(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                                input logic full);
        logic [DATA_W-1:0] m;
        m = (a > b) ? a : b;
        if (!full)
            for (int i = 0; i < LANES; i++)
                m[i*LW +: LW] = (a[i*LW +: LW] > b[i*LW +: LW]) ? a[i*LW +: LW] : b[i*LW +: LW];
        return m;
    endfunction

    assign bus.in_ready   = (r_state == RUN) & (~r_out_valid | bus.out_ready);
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.busy       = (r_state != IDLE);
    assign bus.frame_done = r_frame_done;

    assign w_acc        = bus.in_valid & bus.in_ready;
    assign w_out_hs     = r_out_valid & bus.out_ready;
    assign w_start      = (r_state == IDLE) & bus.start;
    assign w_first      = (r_kc == '0) & (r_wr == '0);
    assign w_win_last   = (r_kc == K_LAST) & (r_wr == K_LAST);
    assign w_frame_last = w_win_last & (r_j == J_LAST) & (r_row == R_LAST);
    assign w_max        = f_max(r_pbuf[r_j], bus.in_data, r_mode);

    // Next state: DRAIN waits for the final pooled word to be taken before going idle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.start ? RUN : IDLE;
            RUN:     w_next = (w_acc & w_frame_last) ? DRAIN : RUN;
            DRAIN:   w_next = w_out_hs ? IDLE : DRAIN;
            default: w_next = IDLE;
        endcase
    end

    // State register, compare mode latched only when a frame starts, end-of-frame pulse.
    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            r_state      <= IDLE;
            r_mode       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_frame_done <= (r_state == DRAIN) & w_out_hs;
            if (w_start)
                r_mode <= bus.full_width;
        end
    end

    // Position counters: column-in-window, window column, row-in-window, window row.
    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            r_kc  <= '0;
            r_j   <= '0;
            r_wr  <= '0;
            r_row <= '0;
        end else if (w_start) begin
            r_kc  <= '0;
            r_j   <= '0;
            r_wr  <= '0;
            r_row <= '0;
        end else if (w_acc) begin
            r_kc <= (r_kc == K_LAST) ? '0 : r_kc + KW'(1);
            if (r_kc == K_LAST) begin
                r_j <= (r_j == J_LAST) ? '0 : r_j + JW'(1);
                if (r_j == J_LAST) begin
                    r_wr <= (r_wr == K_LAST) ? '0 : r_wr + KW'(1);
                    if (r_wr == K_LAST)
                        r_row <= (r_row == R_LAST) ? '0 : r_row + RW'(1);
                end
            end
        end
    end

    // Running window maxima; the first pixel of a window overwrites, so old frames never leak in.
    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            for (int i = 0; i < NJ; i++)
                r_pbuf[i] <= '0;
        end else if (w_acc) begin
            r_pbuf[r_j] <= w_first ? bus.in_data : w_max;
        end
    end

    // Output register: a new result may replace the word being handed off in the same cycle.
    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_acc & w_win_last) begin
            r_out_data  <= w_max;
            r_out_valid <= 1'b1;
        end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pool_stream_max.sv
// tb_pool_stream_max: directed scoreboard bench for the streaming max-pooler
module tb_pool_stream_max;
    localparam int DATA_W = 14;
    localparam int LANES  = 2;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 8;
    localparam int POOL_K = 2;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int NOUT   = (IMG_W / POOL_K) * (IMG_H / POOL_K);
    localparam int LW     = DATA_W / LANES;

    logic clk = 1'b0;
    logic a_reset = 1'b1;

    pool_stream_max_if #(.DATA_W(DATA_W)) bus ();

    pool_stream_max #(
        .DATA_W(DATA_W), .LANES(LANES), .IMG_W(IMG_W), .IMG_H(IMG_H), .POOL_K(POOL_K)
    ) dut (
        .clk(clk),
        .a_reset(a_reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errs = 0;
    int n_out = 0;
    int n_fd = 0;
    logic [DATA_W-1:0] sb [$];
    logic [DATA_W-1:0] pix [NPIX];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: per window, take the maximum of each lane field (or of the whole word).
    function automatic void push_model(input logic mode);
        for (int wy = 0; wy < IMG_H / POOL_K; wy++)
            for (int wx = 0; wx < IMG_W / POOL_K; wx++) begin
                logic [DATA_W-1:0] res;
                res = '0;
                for (int l = 0; l < (mode ? 1 : LANES); l++) begin
                    int best;
                    best = 0;
                    for (int dy = 0; dy < POOL_K; dy++)
                        for (int dx = 0; dx < POOL_K; dx++) begin
                            int full;
                            int v;
                            full = int'(pix[(wy*POOL_K + dy)*IMG_W + wx*POOL_K + dx]);
                            v = mode ? full : (full >> (l*LW)) % (1 << LW);
                            if (v > best) best = v;
                        end
                    res = res | DATA_W'(best << (mode ? 0 : l*LW));
                end
                sb.push_back(res);
            end
    endfunction

    // Monitor: consumes one scoreboard entry per output handshake, counts frame_done pulses.
    always @(negedge clk) begin
        if (bus.frame_done) n_fd++;
        if (bus.out_valid && bus.out_ready) begin
            n_out++;
            if (sb.size() == 0)
                check("unexpected_output", 32'(sb.size()), 32'd1);
            else
                check("out_data", 32'(bus.out_data), 32'(sb.pop_front()));
        end
    end

    task automatic run_frame(input logic mode, input int mid, input int abort_n);
        int n;
        bus.full_width = mode;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        for (int p = 0; p < NPIX; p++) begin
            if (abort_n > 0 && p == abort_n) begin
                bus.in_valid = 1'b0;
                return;
            end
            bus.in_valid = 1'b1;
            bus.in_data = pix[p];
            if (p == mid) begin
                bus.start = 1'b1;
                bus.full_width = ~mode;
            end
            n = 0;
            @(negedge clk);
            while (!bus.in_ready && n < 200) begin
                n++;
                @(negedge clk);
            end
            if (n >= 200) begin
                check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.full_width = mode;
        end
        bus.in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.frame_done && n < 500) begin
            n++;
            @(negedge clk);
        end
        check("frame_done_seen", 32'(bus.frame_done), 32'd1);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errs);
        $fatal(1, "watchdog");
    end

    initial begin
        int o0;
        int f0;
        bus.start = 1'b0;
        bus.full_width = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        a_reset = 1'b0;
        @(posedge clk); #1;

        // Reset mid-frame after 10 pixels (first window result pending)
        for (int p = 0; p < NPIX; p++) pix[p] = DATA_W'(p);
        bus.out_ready = 1'b0;
        run_frame(1'b1, -1, 10);
        check("pre_reset_out_valid", 32'(bus.out_valid), 32'd1);
        a_reset = 1'b1;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        check("midrst_out_data", 32'(bus.out_data), 32'd0);
        @(posedge clk); #1;
        a_reset = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("midrst_no_frame_done", 32'(n_fd), 32'd0);

        // Full-width ramp frame: pixel(r,c) = 8r+c, max is the bottom-right pixel of each window
        for (int wy = 0; wy < IMG_H / POOL_K; wy++)
            for (int wx = 0; wx < IMG_W / POOL_K; wx++)
                sb.push_back(DATA_W'((wy*POOL_K + POOL_K - 1)*IMG_W + wx*POOL_K + POOL_K - 1));
        o0 = n_out;
        run_frame(1'b1, -1, 0);
        check("ramp_out_count", 32'(n_out - o0), 32'(NOUT));
        repeat (2) @(posedge clk);
        #1;
        check("ramp_frame_done_once", 32'(n_fd), 32'd1);

        // Packed vs full-width on one crafted window
        for (int p = 0; p < NPIX; p++) pix[p] = '0;
        pix[0] = 14'b1111111_0000001;
        pix[1] = 14'b0000001_1111111;
        sb.push_back(14'h3FFF);
        for (int i = 1; i < NOUT; i++) sb.push_back('0);
        run_frame(1'b0, -1, 0);
        @(posedge clk); #1;
        sb.push_back(14'h3F81);
        for (int i = 1; i < NOUT; i++) sb.push_back('0);
        run_frame(1'b1, -1, 0);
        @(posedge clk); #1;

        // Backpressure: consumer stalls, input must stall and the pending word must hold
        for (int p = 0; p < NPIX; p++) pix[p] = DATA_W'($urandom);
        push_model(1'b1);
        o0 = n_out;
        bus.out_ready = 1'b0;
        fork
            run_frame(1'b1, -1, 0);
            begin
                repeat (15) @(negedge clk);
                check("bp_out_valid", 32'(bus.out_valid), 32'd1);
                check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
                check("bp_out_data", 32'(bus.out_data), 32'(sb[0]));
                repeat (5) @(negedge clk);
                check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
                check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
                check("bp_hold_data", 32'(bus.out_data), 32'(sb[0]));
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
        join
        check("bp_out_count", 32'(n_out - o0), 32'(NOUT));
        @(posedge clk); #1;

        // Mid-frame start and full_width toggle are ignored; packed mode stays in force
        for (int p = 0; p < NPIX; p++) pix[p] = DATA_W'($urandom);
        push_model(1'b0);
        o0 = n_out;
        run_frame(1'b0, 20, 0);
        check("ignore_out_count", 32'(n_out - o0), 32'(NOUT));

        // Pixels offered while idle are refused
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_data = 14'h1234;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_in_ready", 32'(bus.in_ready), 32'd0);
            check("idle_busy", 32'(bus.busy), 32'd0);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("idle_no_output", 32'(bus.out_valid), 32'd0);

        // Back-to-back: start raised during the frame_done cycle; second frame all zeros
        for (int p = 0; p < NPIX; p++) pix[p] = DATA_W'($urandom_range(1, 16383));
        push_model(1'b1);
        f0 = n_fd;
        run_frame(1'b1, -1, 0);
        check("b2b_frame_done_now", 32'(bus.frame_done), 32'd1);
        for (int p = 0; p < NPIX; p++) pix[p] = '0;
        for (int i = 0; i < NOUT; i++) sb.push_back('0);
        o0 = n_out;
        run_frame(1'b1, -1, 0);
        check("b2b_out_count", 32'(n_out - o0), 32'(NOUT));
        repeat (2) @(posedge clk);
        #1;
        check("b2b_frame_done_count", 32'(n_fd - f0), 32'd2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
